bcd_seq_converter: RTL and testbench
====================================

# bcd_seq_converter

Multi-cycle binary-to-BCD converter controller. It sequences an iterative shift/add-3 (double-dabble) datapath, one bit per clock, to convert a WIDTH-bit binary word into DIGITS packed BCD digits. It generalises the team's 4-bit combinational BCD encoder to arbitrary widths. Valid/ready handshakes sit on both sides so it can be placed between a binary producer and a display or UART formatter.

## Interface
- WIDTH, 8: binary input width; ≥ 1.
- DIGITS, 3: number of BCD output digits; ≥ 1.
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  `bin` is valid.
- in_ready  output  1  converter can accept; high only in IDLE.
- bin  input  WIDTH  unsigned binary operand.
- out_valid  output  1  `bcd`/`ovf` hold a completed result; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- bcd  output  4*DIGITS  packed BCD, digit 0 in [3:0]; registered.
- ovf  output  1  result truncated: value ≥ 10^DIGITS.
- busy  output  1  high in SHIFT or DONE.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch `bin` into the shift register, clear the BCD accumulator and the sticky overflow, load count=WIDTH, go to SHIFT.
- SHIFT, one iteration per cycle:
  - Add 3 to every accumulator digit that is ≥ 5.
  - Shift {accumulator, binary} left by 1.
  - The bit shifted out of the top digit is ORed into the sticky overflow.
  - Decrement count. When count reaches 1 on this edge, go to DONE and load `bcd` and `ovf` from the post-iteration values.
- DONE:
  - out_valid=1.
  - On out_ready, go to IDLE.
  - in_ready=0, so there is no overlap between result and next accept.
- Truncation: on overflow, `bcd` equals value mod 10^DIGITS, because dropped carries are discarded. No saturation.
- in_valid outside IDLE is ignored, and `bin` is not sampled then.
- `bcd`/`ovf` are loaded only on the SHIFT→DONE edge. They stay stable through DONE and keep the last result in IDLE.
- Counter width is $clog2(WIDTH+1). WIDTH=1 is legal and gives a single SHIFT cycle.

## Timing
- Reset values: in_ready=1 (state IDLE), out_valid=0, busy=0, bcd=0, ovf=0. The internal accumulator, shift register and count are all 0.
- rst asserted in any state, including mid-SHIFT or in DONE, forces the reset values on the next edge. Any in-flight conversion is discarded with no partial output.
- Latency: if the accept handshake occurs at edge E0, then out_valid rises at edge E_WIDTH, which is 8 cycles for the default.
- Throughput: one conversion per WIDTH+2 cycles when out_ready is held high. The cycles are SHIFT×WIDTH, DONE×1 and IDLE×1.
- With out_ready held high, out_valid is a 1-cycle pulse. With out_ready low, out_valid, bcd and ovf are held indefinitely.
- Simultaneous rst and handshake: rst wins.

## Structure
- Package `bcd_pkg` holds:
  - the state enum (IDLE/SHIFT/DONE);
  - DIGIT_W=4;
  - ADD3_THRESH=5;
  - ADD3_VAL=3.
- Sub-module `bcd_add3_digit` is combinational. It takes a 4-bit digit in and gives the corrected digit out, and is instantiated DIGITS times in a generate loop.
- The FSM, counter, shift registers and output registers sit in the top module.

## Test plan
- Reset check: hold rst 2 cycles. Require in_ready=1, out_valid=0, busy=0, bcd=12'h000, ovf=0.
- Default instance, bin=8'd255, out_ready=1:
  - out_valid is high exactly 8 cycles after the accept edge, for 1 cycle.
  - bcd=12'h255, ovf=0.
  - Repeat for 0→12'h000, 99→12'h099 and 128→12'h128.
- Backpressure: bin=8'd37 with out_ready=0 for 5 cycles.
  - out_valid stays high and bcd=12'h037 is stable.
  - in_ready=0, and in_valid with bin=8'd200 in this window is not accepted.
  - Then raise out_ready: IDLE follows on the next edge, and 200 is accepted next, giving 12'h200.
- Reset mid-operation: assert rst after 4 SHIFT cycles of bin=8'd173.
  - Next cycle: IDLE with all outputs at reset values.
  - A following bin=8'd42 yields 12'h042.
- WIDTH=8, DIGITS=2 instance:
  - bin=8'd200 → bcd=8'h00, ovf=1.
  - bin=8'd99 → bcd=8'h99, ovf=0, so ovf has cleared.
  - bin=8'd100 → bcd=8'h00, ovf=1.
- WIDTH=4, DIGITS=2 instance: sweep bin 0–15 exhaustively.
  - bcd equals the 4-bit encoder's decimal value, e.g. 4'b1111 → 8'h15, with latency 4 and ovf always 0.

Source files
------------

// File: rtl/bcd_seq_converter_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
//   state_t     : controller states (IDLE, SHIFT, DONE)
//   DIGIT_W     : bits per packed BCD digit
//   ADD3_THRESH : a digit at or above this value is corrected before a shift
//   ADD3_VAL    : correction added so the doubled digit carries at 10, not 16
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DIGIT_W     = 4;
    localparam int ADD3_THRESH = 5;
    localparam int ADD3_VAL    = 3;

endpackage

// File: rtl/bcd_seq_converter_if.sv
// Handshake bundle for bcd_seq_converter.
//   in_valid/in_ready/bin        : binary operand channel (producer -> converter)
//   out_valid/out_ready/bcd/ovf  : result channel (converter -> consumer)
// master : the side that drives operands and accepts results
// slave  : the converter itself
interface bcd_seq_converter_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      bin;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   bcd;
    logic                  ovf;

    modport master (
        output in_valid, bin, out_ready,
        input  in_ready, out_valid, bcd, ovf
    );

    modport slave (
        input  in_valid, bin, out_ready,
        output in_ready, out_valid, bcd, ovf
    );
endinterface

// File: rtl/bcd_seq_converter_add3.sv
// bcd_add3_digit: combinational double-dabble correction for one BCD digit.
//   digit_in  : accumulator digit before the shift
//   digit_out : digit_in + 3 when digit_in >= 5, otherwise digit_in unchanged
import bcd_pkg::*;

module bcd_add3_digit (
    input  logic [DIGIT_W-1:0] digit_in,
    output logic [DIGIT_W-1:0] digit_out
);
    always_comb begin
        digit_out = digit_in;
        if (digit_in >= DIGIT_W'(ADD3_THRESH)) begin
            digit_out = digit_in + DIGIT_W'(ADD3_VAL);
        end
    end
endmodule

// File: rtl/bcd_seq_converter.sv
// bcd_seq_converter: iterative binary-to-BCD converter, one bit per clock.
//   clk  : clock, all logic on the rising edge
//   rst  : synchronous active-high reset
//   io   : slave side of bcd_seq_converter_if
//          (in_valid/in_ready/bin operand channel, out_valid/out_ready/bcd/ovf
//           result channel; bcd is packed, digit 0 in [3:0])
//   busy : high while a conversion is in progress or its result is pending
// An accepted operand takes WIDTH SHIFT cycles, then the result is held in DONE
// until the consumer takes it. ovf flags values >= 10^DIGITS; in that case bcd
// holds the value modulo 10^DIGITS.
import bcd_pkg::*;

module bcd_seq_converter #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_seq_converter_if.slave   io,
    output logic                 busy
);
    localparam int ACC_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t              state_reg;
    logic [ACC_W-1:0]    acc_reg;
    logic [WIDTH-1:0]    bin_reg;
    logic [CNT_W-1:0]    cnt_reg;
    logic                sticky_reg;
    logic [ACC_W-1:0]    bcd_reg;
    logic                ovf_reg;
    logic                in_ready_reg;
    logic                out_valid_reg;
    logic                busy_reg;

    logic [ACC_W-1:0]    acc_corr;
    logic [ACC_W-1:0]    acc_next;
    logic [WIDTH-1:0]    bin_next;
    logic                sticky_next;

    // Per-digit add-3 correction applied before every shift.
    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_add3
            bcd_add3_digit u_add3 (
                .digit_in  (acc_reg[gi*DIGIT_W +: DIGIT_W]),
                .digit_out (acc_corr[gi*DIGIT_W +: DIGIT_W])
            );
        end
    endgenerate

    // One shift of {accumulator, binary}. The bit leaving the top digit is a
    // decimal carry past 10^DIGITS, so it is kept only in the sticky overflow.
    always_comb begin
        acc_next    = {acc_corr[ACC_W-2:0], bin_reg[WIDTH-1]};
        bin_next    = bin_reg << 1;
        sticky_next = sticky_reg | acc_corr[ACC_W-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            bin_reg       <= '0;
            cnt_reg       <= '0;
            sticky_reg    <= 1'b0;
            bcd_reg       <= '0;
            ovf_reg       <= 1'b0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (io.in_valid) begin
                        bin_reg      <= io.bin;
                        acc_reg      <= '0;
                        sticky_reg   <= 1'b0;
                        cnt_reg      <= CNT_W'(WIDTH);
                        state_reg    <= SHIFT;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                    end
                end
                SHIFT: begin
                    acc_reg    <= acc_next;
                    bin_reg    <= bin_next;
                    sticky_reg <= sticky_next;
                    cnt_reg    <= cnt_reg - CNT_W'(1);
                    // count==1 means this edge performs the final iteration.
                    if (cnt_reg == CNT_W'(1)) begin
                        state_reg     <= DONE;
                        bcd_reg       <= acc_next;
                        ovf_reg       <= sticky_next;
                        out_valid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    if (io.out_ready) begin
                        state_reg     <= IDLE;
                        out_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        in_ready_reg  <= 1'b1;
                    end
                end
                default: begin
                    state_reg     <= IDLE;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    in_ready_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign io.in_ready  = in_ready_reg;
    assign io.out_valid = out_valid_reg;
    assign io.bcd       = bcd_reg;
    assign io.ovf       = ovf_reg;
    assign busy         = busy_reg;

endmodule

// File: tb/tb_bcd_seq_converter.sv
`timescale 1ns/1ps

module tb_bcd_seq_converter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance 0: 8-bit/3 digits, 1: 8-bit/2 digits, 2: 4-bit/2 digits
    bcd_seq_converter_if #(.WIDTH(8), .DIGITS(3)) ia ();
    bcd_seq_converter_if #(.WIDTH(8), .DIGITS(2)) ib ();
    bcd_seq_converter_if #(.WIDTH(4), .DIGITS(2)) ic ();
    logic busy_a, busy_b, busy_c;

    bcd_seq_converter #(.WIDTH(8), .DIGITS(3)) dut_a (.clk(clk), .rst(rst), .io(ia), .busy(busy_a));
    bcd_seq_converter #(.WIDTH(8), .DIGITS(2)) dut_b (.clk(clk), .rst(rst), .io(ib), .busy(busy_b));
    bcd_seq_converter #(.WIDTH(4), .DIGITS(2)) dut_c (.clk(clk), .rst(rst), .io(ic), .busy(busy_c));

    typedef struct {
        logic [11:0] bcd;
        logic        ovf;
        int          acc;
        int          val;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t qc[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit rnd_rdy = 1'b0;

    bit          prev_v [3];
    logic [11:0] prev_b [3];
    logic        prev_o [3];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     name, act, act, exp, exp, cyc);
        end
    endtask

    function automatic int width_of(input int id);
        return (id == 2) ? 4 : 8;
    endfunction

    function automatic int digits_of(input int id);
        return (id == 0) ? 3 : 2;
    endfunction

    // Reference: decimal digits of (v mod 10^D), overflow when v >= 10^D.
    function automatic exp_t model(input int v, input int digits, input int acc);
        exp_t        e;
        int          m;
        int          r;
        logic [11:0] b;
        m = 1;
        for (int i = 0; i < digits; i++) m = m * 10;
        r = v % m;
        b = '0;
        for (int i = 0; i < digits; i++) begin
            b[i*4 +: 4] = 4'(r % 10);
            r = r / 10;
        end
        e.bcd = b;
        e.ovf = (v >= m);
        e.acc = acc;
        e.val = v;
        return e;
    endfunction

    // Called at the negedge preceding the accepting edge.
    task automatic push(input int id, input int v);
        exp_t e;
        e = model(v, digits_of(id), cyc + 1);
        case (id)
            0: qa.push_back(e);
            1: qb.push_back(e);
            default: qc.push_back(e);
        endcase
    endtask

    task automatic set_in(input int id, input logic vld, input int v);
        case (id)
            0: begin ia.in_valid = vld; ia.bin = 8'(v); end
            1: begin ib.in_valid = vld; ib.bin = 8'(v); end
            default: begin ic.in_valid = vld; ic.bin = 4'(v); end
        endcase
    endtask

    function automatic logic get_ready(input int id);
        case (id)
            0: return ia.in_ready;
            1: return ib.in_ready;
            default: return ic.in_ready;
        endcase
    endfunction

    task automatic send(input int id, input int v);
        int tries;
        tries = 0;
        @(negedge clk);
        set_in(id, 1'b1, v);
        while (!get_ready(id) && tries < 300) begin
            @(negedge clk);
            tries++;
        end
        if (tries >= 300) begin
            chk("accept_timeout", 0, 1);
            set_in(id, 1'b0, 0);
        end else begin
            push(id, v);
            @(negedge clk);
            set_in(id, 1'b0, 0);
        end
    endtask

    task automatic mon(input int id, input logic v, input logic [11:0] b, input logic o,
                       input logic rdy, input logic ordy, input logic bsy);
        exp_t e;
        int   n;
        if (v) begin
            chk("in_ready_low_in_done", int'(rdy), 0);
            chk("busy_in_done", int'(bsy), 1);
            if (!prev_v[id]) begin
                case (id)
                    0: n = qa.size();
                    1: n = qb.size();
                    default: n = qc.size();
                endcase
                if (n == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    case (id)
                        0: e = qa.pop_front();
                        1: e = qb.pop_front();
                        default: e = qc.pop_front();
                    endcase
                    $display("txn inst=%0d bin=%0d bcd=0x%03h ovf=%0d latency=%0d",
                             id, e.val, b, o, cyc - e.acc);
                    chk("bcd", int'(b), int'(e.bcd));
                    chk("ovf", int'(o), int'(e.ovf));
                    chk("latency", cyc - e.acc, width_of(id));
                end
            end else begin
                chk("bcd_stable", int'(b), int'(prev_b[id]));
                chk("ovf_stable", int'(o), int'(prev_o[id]));
                // A result seen on the previous edge with out_ready high must be gone.
                if (ordy) chk("out_valid_pulse", int'(v), 0);
            end
        end
        prev_v[id] = v;
        prev_b[id] = b;
        prev_o[id] = o;
    endtask

    // Monitor samples just after each rising edge; all driving happens on negedges.
    always @(posedge clk) begin
        #1;
        mon(0, ia.out_valid, 12'(ia.bcd), ia.ovf, ia.in_ready, ia.out_ready, busy_a);
        mon(1, ib.out_valid, 12'(ib.bcd), ib.ovf, ib.in_ready, ib.out_ready, busy_b);
        mon(2, ic.out_valid, 12'(ic.bcd), ic.ovf, ic.in_ready, ic.out_ready, busy_c);
    end

    always @(negedge clk) begin
        if (rnd_rdy) begin
            ia.out_ready = 1'($urandom % 2);
            ib.out_ready = 1'($urandom % 2);
            ic.out_ready = 1'($urandom % 2);
        end
    end

    task automatic drain();
        for (int i = 0; i < 400; i++) begin
            if (qa.size() == 0 && qb.size() == 0 && qc.size() == 0 &&
                !ia.out_valid && !ib.out_valid && !ic.out_valid) return;
            @(negedge clk);
        end
        chk("drain_timeout", 0, 1);
    endtask

    initial begin
        int tries;
        rst = 1'b1;
        ia.in_valid = 1'b0; ia.bin = '0; ia.out_ready = 1'b1;
        ib.in_valid = 1'b0; ib.bin = '0; ib.out_ready = 1'b1;
        ic.in_valid = 1'b0; ic.bin = '0; ic.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", int'(ia.in_ready), 1);
        chk("rst_out_valid", int'(ia.out_valid), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_bcd", int'(ia.bcd), 0);
        chk("rst_ovf", int'(ia.ovf), 0);
        rst = 1'b0;

        // Directed conversions, default instance.
        send(0, 255);
        send(0, 0);
        send(0, 99);
        send(0, 128);
        drain();

        // Backpressure: result held, 200 offered during DONE must not be taken.
        ia.out_ready = 1'b0;
        send(0, 37);
        tries = 0;
        while (!ia.out_valid && tries < 30) begin
            @(negedge clk);
            tries++;
        end
        chk("bp_result_seen", int'(ia.out_valid), 1);
        set_in(0, 1'b1, 200);
        repeat (5) begin
            @(negedge clk);
            chk("bp_out_valid_held", int'(ia.out_valid), 1);
            chk("bp_bcd_held", int'(ia.bcd), 'h037);
            chk("bp_in_ready_low", int'(ia.in_ready), 0);
        end
        ia.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_idle_after_ready", int'(ia.in_ready), 1);
        chk("bp_out_valid_drop", int'(ia.out_valid), 0);
        push(0, 200);
        @(negedge clk);
        set_in(0, 1'b0, 0);
        drain();

        // Reset in the middle of SHIFT discards the conversion.
        send(0, 173);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        qa.delete();
        @(negedge clk);
        chk("midrst_in_ready", int'(ia.in_ready), 1);
        chk("midrst_out_valid", int'(ia.out_valid), 0);
        chk("midrst_busy", int'(busy_a), 0);
        chk("midrst_bcd", int'(ia.bcd), 0);
        chk("midrst_ovf", int'(ia.ovf), 0);
        rst = 1'b0;
        send(0, 42);
        drain();

        // Two-digit instance: truncation and sticky overflow clearing.
        send(1, 200);
        send(1, 99);
        send(1, 100);
        drain();

        // Four-bit instance: exhaustive sweep.
        for (int v = 0; v < 16; v++) send(2, v);
        drain();

        // Random operands across instances with random consumer backpressure.
        rnd_rdy = 1'b1;
        for (int k = 0; k < 30; k++) begin
            int id;
            id = int'($urandom_range(0, 2));
            send(id, int'($urandom_range(0, (1 << width_of(id)) - 1)));
        end
        @(negedge clk);
        rnd_rdy = 1'b0;
        ia.out_ready = 1'b1;
        ib.out_ready = 1'b1;
        ic.out_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
